fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin write-side arbiter that shares the single write port of one `fifo` instance among `NUM_REQ` producers. Each producer has a valid/ready channel. The arbiter grants one producer per cycle, can hold a grant for a burst of up to `MAX_BURST` beats, and registers the winning beat onto the FIFO's `w_valid`/`data_in`. It uses the FIFO's `pre_full`/`fifo_full` flags so that no beat is ever written into a full FIFO.

## Interface

Parameters:
- `WIDTH`, 32: data width per beat.
- `NUM_REQ`, 4: number of producers, 2..16.
- `MAX_BURST`, 4: maximum beats per grant, 1..255.
- `ID_W`, `$clog2(NUM_REQ)`: width of the source-id field.

Ports (`reset` is synchronous, active-low, single clock domain):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-low reset
- `req_valid`  in  NUM_REQ  per-producer beat valid
- `req_data`  in  NUM_REQ*WIDTH  producer i occupies bits [i*WIDTH +: WIDTH]
- `req_ready`  out  NUM_REQ  one-hot-or-zero; beat of producer i accepted when valid&ready at posedge
- `fifo_pre_full`  in  1  FIFO `pre_full`: at most one free entry
- `fifo_full`  in  1  FIFO `fifo_full`
- `w_valid`  out  1  to FIFO `w_valid`, registered
- `data_in`  out  WIDTH  to FIFO `data_in`, registered
- `src_id`  out  ID_W  producer index of the beat on `data_in`, registered
- `busy`  out  1  high in state LOCK

## Operation

- **Space rule:**
  - `space = !fifo_full && !(fifo_pre_full && w_valid)`.
  - The registered write in flight is counted against the last free slot.
- **States:**
  - `IDLE`: no owner.
  - `LOCK`: owner register `own` holds the granted producer; beat counter `cnt` runs 0..MAX_BURST-1.
- **In `IDLE`:**
  - If `space` and any `req_valid` is set, the picker selects the first valid index searching from `rr_ptr` upward, with wrap-around.
  - `req_ready[pick]` = 1 in the same cycle.
  - On that transfer: `own <= pick`, `cnt <= 1`.
  - Go to `LOCK` if MAX_BURST > 1. Otherwise stay in `IDLE` and set `rr_ptr <= pick+1` (mod NUM_REQ).
- **In `LOCK`:** `req_ready[own] = space`; all other ready bits are 0.
  - Transfer: `cnt++`. When the incremented value equals MAX_BURST, go to `IDLE` and set `rr_ptr <= own+1`.
  - `req_valid[own]` low, whether or not there is space: go to `IDLE` with `rr_ptr <= own+1`. No transfer occurs this cycle.
  - `req_valid[own]` high but no `space`: hold `own` and `cnt`. A stall never releases the lock.
- **Every transfer:** `w_valid <= 1`, `data_in <= req_data[sel]`, `src_id <= sel`.
- **Cycles without a transfer:** `w_valid <= 0`; `data_in` and `src_id` hold their values.
- **`rr_ptr` arithmetic:** wraps from NUM_REQ-1 to 0. For non-power-of-two NUM_REQ, indices ≥ NUM_REQ are never produced.
- **Reset:** any in-flight beat is discarded. Outputs take reset values at the next edge.

## Timing

- **Reset values:** `w_valid`=0, `data_in`=0, `src_id`=0, `busy`=0, `req_ready`=0, state=`IDLE`, `rr_ptr`=0, `cnt`=0.
- **`req_ready`:** combinational from state, `req_valid`, `fifo_*` flags and `w_valid`. It is forced to 0 while `reset`=0.
- **Latency:** a producer's beat accepted at edge N appears on `w_valid`/`data_in` after edge N and is written into the FIFO at edge N+1.
- **Throughput:** 1 beat/cycle while `space` holds.
- **IDLE→new grant:** one cycle with no transfer after a burst ends by valid-drop. No bubble occurs after a burst ends by count.
- **Simultaneous valid from all producers:** grant order is `rr_ptr`, `rr_ptr`+1, …, each producer getting up to MAX_BURST beats.
- **`fifo_pre_full` rises with a write in flight:** `req_ready` drops in the same cycle. There is never a write while `fifo_full`=1.

## Structure

- **Package `fifo_arb_pkg`:** state enum (`IDLE`, `LOCK`) and a `next_idx(idx, n)` wrap-increment function.
- **Sub-module `rr_pick`:** combinational; inputs `valid[NUM_REQ]` and `ptr`; outputs `any` and `idx`. This is the rotate-priority-encode.
- **Top:** FSM, counter, output register.

## Test plan

NUM_REQ=4, WIDTH=32, MAX_BURST=4, driving a `fifo` of DEPTH=3 that is drained continuously.

1. **Reset:** hold `reset`=0 for 2 cycles with all `req_valid`=1 → `req_ready`=0 and `w_valid`=0 throughout; after release the first grant goes to producer 0.
2. **All four producers valid,** each carrying 0x10·i+beat → FIFO receives 0x00..0x03, 0x10..0x13, 0x20..0x23, 0x30..0x33 in that order, with matching `src_id`.
3. **Producer 2 valid for 2 beats, then low** → burst of 2 beats, `busy` drops, `rr_ptr`=3, and producer 3 is granted next when valid.
4. **FIFO drain stopped with producer 1 streaming** → exactly 3 beats are written, and `req_ready` stays low while `pre_full`/`full` block. After drain resumes, beats 4.. continue with none lost or duplicated and `own`=1 held.
5. **Only producer 0 valid, continuous** → bursts of 4 beats with one re-grant each, back to back, and no `w_valid` gap.
6. **Reset asserted mid-burst** (producer 3 at cnt=2) → at the next edge `w_valid`=0 and state=`IDLE`; after release, producer 0 has priority.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Increment with wrap at n; never yields a value >= n.
  function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating priority encoder: first set valid bit at or after ptr, with wrap.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    idx
);

  // Index that sits k positions after p, modulo NUM_REQ (p is always < NUM_REQ).
  function automatic int unsigned rot(input logic [ID_W-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    return (s >= NUM_REQ) ? s - NUM_REQ : s;
  endfunction

  // Scan from the farthest offset down so the nearest valid index wins last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int unsigned k = NUM_REQ; k > 0; k--) begin
      if (valid[ID_W'(rot(ptr, k - 1))]) begin
        any = 1'b1;
        idx = ID_W'(rot(ptr, k - 1));
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     fifo_pre_full,
  input  logic                     fifo_full,
  output logic                     w_valid,
  output logic [WIDTH-1:0]         data_in,
  output logic [ID_W-1:0]          src_id,
  output logic                     busy
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_e                      state, state_nxt;
  logic [ID_W-1:0]                 own, rr_ptr, pick, sel;
  logic [CNT_W-1:0]                cnt;
  logic                            any, space, xfer;
  logic [NUM_REQ-1:0][WIDTH-1:0]   lanes;

  assign lanes = req_data;
  // The registered beat still in flight occupies the last free slot.
  assign space = !fifo_full && !(fifo_pre_full && w_valid);
  assign busy  = (state == LOCK);

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .any   (any),
    .idx   (pick)
  );

  // Grant decode and next state; ready is held off while in reset.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    xfer      = 1'b0;
    sel       = own;
    case (state)
      IDLE: begin
        sel = pick;
        if (space && any) begin
          req_ready[pick] = 1'b1;
          xfer            = 1'b1;
          if (MAX_BURST > 1) state_nxt = LOCK;
        end
      end
      LOCK: begin
        req_ready[own] = space;
        xfer           = space && req_valid[own];
        // A stall with valid held never releases; valid-drop or last beat does.
        if (!req_valid[own] || (xfer && cnt == CNT_W'(MAX_BURST - 1)))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (!reset) begin
      req_ready = '0;
      xfer      = 1'b0;
    end
  end

  // State, owner, beat counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      own    <= '0;
      cnt    <= '0;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (xfer) begin
          own <= pick;
          cnt <= CNT_W'(1);
          if (MAX_BURST == 1) rr_ptr <= ID_W'(next_idx(32'(pick), NUM_REQ));
        end
      end else if (state_nxt == IDLE) begin
        rr_ptr <= ID_W'(next_idx(32'(own), NUM_REQ));
        cnt    <= '0;
      end else if (xfer) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Registered write port; data and id hold between transfers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      w_valid <= 1'b0;
      data_in <= '0;
      src_id  <= '0;
    end else begin
      w_valid <= xfer;
      if (xfer) begin
        data_in <= lanes[sel];
        src_id  <= sel;
      end
    end
  end

endmodule
